gcn_addr_sequencer: RTL and testbench

//  2-D address sequencer for GCN weight/feature SRAM reads; successor to the single-axis wrap counter.

---
 rtl/gcn_addr_pkg.sv | 15 +
 rtl/gcn_wrap_counter.sv | 39 +++
 rtl/gcn_addr_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_gcn_addr_sequencer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gcn_addr_pkg.sv
// Shared types and default widths for the GCN address sequencer.
// Imported by gcn_addr_sequencer.
package gcn_addr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  localparam int ROWS_MAX_DEF   = 64;
  localparam int COLS_MAX_DEF   = 16;
  localparam int ADDR_WIDTH_DEF = 12;

endpackage

// File: rtl/gcn_wrap_counter.sv
// Index counter for one tile axis: counts 0..limit-1 on en, wraps to 0.
// wrap is high on the enabled step that returns the count to 0.
module gcn_wrap_counter #(
  parameter int MAX = 16,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count,
  output logic         wrap
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  assign wrap  = en && (count_q == limit - W'(1));
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (en) begin
      count_d = wrap ? '0 : count_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/gcn_addr_sequencer.sv
// 2-D tile address sequencer for GCN SRAM reads: one address per valid/ready beat.
// Optional column-major walk when GCN_ADDR_SEQ_TRANSPOSE_EN is defined.
//
// state | meaning
// IDLE  | waiting for start, cfg sampled on start
// RUN   | issuing addresses, busy high
// DONE  | one cycle, done pulse, back to IDLE
module gcn_addr_sequencer
  import gcn_addr_pkg::*;
#(
  parameter  int ROWS_MAX   = ROWS_MAX_DEF,
  parameter  int COLS_MAX   = COLS_MAX_DEF,
  parameter  int ADDR_WIDTH = ADDR_WIDTH_DEF,
  localparam int RW         = $clog2(ROWS_MAX + 1),
  localparam int CW         = $clog2(COLS_MAX + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  clear,
  input  logic [RW-1:0]         cfg_rows,
  input  logic [CW-1:0]         cfg_cols,
  input  logic [ADDR_WIDTH-1:0] cfg_base,
  input  logic [ADDR_WIDTH-1:0] cfg_row_stride,
`ifdef GCN_ADDR_SEQ_TRANSPOSE_EN
  input  logic                  cfg_col_major,
`endif
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  addr_valid,
  input  logic                  addr_ready,
  output logic                  addr_last,
  output logic                  busy,
  output logic                  done
);

  seq_state_t            state_q;
  logic [RW-1:0]         rows_q;
  logic [CW-1:0]         cols_q;
  logic [ADDR_WIDTH-1:0] stride_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic                  valid_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  col_major;

  logic [RW-1:0] row_cnt;
  logic [CW-1:0] col_cnt;
  logic          row_wrap, col_wrap;
  logic          row_en, col_en;
  logic          row_at_end, col_at_end;
  logic          beat, is_last, start_acc, cnt_clr;

`ifdef GCN_ADDR_SEQ_TRANSPOSE_EN
  logic                  col_major_q;
  logic [ADDR_WIDTH-1:0] base_q;
  assign col_major = col_major_q;
`else
  assign col_major = 1'b0;
`endif

  assign beat       = valid_q & addr_ready;
  assign row_at_end = (row_cnt == rows_q - RW'(1));
  assign col_at_end = (col_cnt == cols_q - CW'(1));
  assign is_last    = row_at_end & col_at_end;
  assign start_acc  = (state_q == IDLE) & start & ~clear;
  assign cnt_clr    = clear | start_acc;

  // Inner axis steps every beat; outer axis steps when the inner one is at its end.
  assign row_en = beat & (col_major | col_at_end);
  assign col_en = beat & (~col_major | row_at_end);

  gcn_wrap_counter #(.MAX(ROWS_MAX), .W(RW)) u_row_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (cnt_clr),
    .en    (row_en),
    .limit (rows_q),
    .count (row_cnt),
    .wrap  (row_wrap)
  );

  gcn_wrap_counter #(.MAX(COLS_MAX), .W(CW)) u_col_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (cnt_clr),
    .en    (col_en),
    .limit (cols_q),
    .count (col_cnt),
    .wrap  (col_wrap)
  );

  always_comb begin
    addr_d = addr_q + ADDR_WIDTH'(1);
`ifdef GCN_ADDR_SEQ_TRANSPOSE_EN
    if (col_major) begin
      addr_d = row_wrap ? base_q + ADDR_WIDTH'(col_cnt) + ADDR_WIDTH'(1)
                        : addr_q + stride_q;
    end else if (col_wrap) begin
      addr_d = addr_q + stride_q - ADDR_WIDTH'(cols_q) + ADDR_WIDTH'(1);
    end
`else
    if (col_wrap) begin
      addr_d = addr_q + stride_q - ADDR_WIDTH'(cols_q) + ADDR_WIDTH'(1);
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rows_q      <= '0;
      cols_q      <= '0;
      stride_q    <= '0;
      addr_q      <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef GCN_ADDR_SEQ_TRANSPOSE_EN
      col_major_q <= 1'b0;
      base_q      <= '0;
`endif
    end else if (clear) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            rows_q      <= cfg_rows;
            cols_q      <= cfg_cols;
            stride_q    <= cfg_row_stride;
            addr_q      <= cfg_base;
`ifdef GCN_ADDR_SEQ_TRANSPOSE_EN
            col_major_q <= cfg_col_major;
            base_q      <= cfg_base;
`endif
            if ((cfg_rows == '0) || (cfg_cols == '0)) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= RUN;
              valid_q <= 1'b1;
              busy_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (beat) begin
            if (is_last) begin
              state_q <= DONE;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              addr_q <= addr_d;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign addr       = addr_q;
  assign addr_valid = valid_q;
  assign addr_last  = valid_q & is_last;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_gcn_addr_sequencer.sv
// Directed self-checking bench for gcn_addr_sequencer (default widths).
// Column-major scenario is built only with GCN_ADDR_SEQ_TRANSPOSE_EN.
module tb_gcn_addr_sequencer;

  localparam int AW = 12;
  localparam int RW = 7;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          clear = 1'b0;
  logic [RW-1:0] cfg_rows = '0;
  logic [CW-1:0] cfg_cols = '0;
  logic [AW-1:0] cfg_base = '0;
  logic [AW-1:0] cfg_row_stride = '0;
  logic          cfg_col_major = 1'b0;
  logic [AW-1:0] addr;
  logic          addr_valid;
  logic          addr_ready = 1'b0;
  logic          addr_last;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] beat_addr [32];
  logic          beat_last [32];
  int            nbeats;
  int            done_at;
  logic          valid_at_done;
  int            stall_bad;
  logic          timed_out;

  always #5 clk = ~clk;

  gcn_addr_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .clear          (clear),
    .cfg_rows       (cfg_rows),
    .cfg_cols       (cfg_cols),
    .cfg_base       (cfg_base),
    .cfg_row_stride (cfg_row_stride),
`ifdef GCN_ADDR_SEQ_TRANSPOSE_EN
    .cfg_col_major  (cfg_col_major),
`endif
    .addr           (addr),
    .addr_valid     (addr_valid),
    .addr_ready     (addr_ready),
    .addr_last      (addr_last),
    .busy           (busy),
    .done           (done)
  );

  // Leaves the caller on the negedge after the start edge.
  task automatic do_start(input int rows, input int cols, input int base,
                          input int stride, input bit cm);
    @(negedge clk);
    cfg_rows       = RW'(rows);
    cfg_cols       = CW'(cols);
    cfg_base       = AW'(base);
    cfg_row_stride = AW'(stride);
    cfg_col_major  = cm;
    start          = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Records accepted beats until done or a cycle budget runs out.
  task automatic collect(input bit toggle);
    bit            ph = 1'b1;
    bit            r;
    bit            prev_stall = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    logic          prev_last = 1'b0;
    int            since_last = -1;
    nbeats = 0; done_at = -1; valid_at_done = 1'b1; stall_bad = 0; timed_out = 1'b1;
    for (int c = 0; c < 300; c++) begin
      if (done) begin
        done_at       = since_last;
        valid_at_done = addr_valid;
        timed_out     = 1'b0;
        break;
      end
      if (prev_stall && (addr !== prev_addr || addr_last !== prev_last)) stall_bad++;
      r = toggle ? ph : 1'b1;
      ph = ~ph;
      addr_ready = r;
      if (addr_valid && r && nbeats < 32) begin
        beat_addr[nbeats] = addr;
        beat_last[nbeats] = addr_last;
        nbeats++;
        if (addr_last) since_last = 0;
      end
      prev_stall = addr_valid && !r;
      prev_addr  = addr;
      prev_last  = addr_last;
      @(negedge clk);
      if (since_last >= 0) since_last++;
    end
    addr_ready = 1'b1;
    checks++;
    if (timed_out) begin
      errors++;
      $display("FAIL collect_timeout: no done within budget, beats=%0d", nbeats);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (addr !== '0) begin errors++; $display("FAIL reset_addr: got %h expected 000", addr); end
    checks++; if (addr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", addr_valid); end
    checks++; if (addr_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b expected 0", addr_last); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    reset = 1'b0;
  endtask

  task automatic test_row_major();
    logic [AW-1:0] exp [6];
    exp[0] = 12'h100; exp[1] = 12'h101; exp[2] = 12'h102;
    exp[3] = 12'h110; exp[4] = 12'h111; exp[5] = 12'h112;
    do_start(2, 3, 'h100, 'h10, 1'b0);
    checks++; if (addr_valid !== 1'b1 || addr !== 12'h100) begin errors++;
      $display("FAIL rm_first: valid=%b addr=%h expected valid=1 addr=100", addr_valid, addr); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rm_busy: got %b expected 1", busy); end
    // Late cfg changes and a held start must not disturb the running tile.
    cfg_base = 12'h555; cfg_rows = 7'd1; cfg_cols = 5'd1; start = 1'b1;
    collect(1'b0);
    start = 1'b0;
    checks++; if (nbeats !== 6) begin errors++; $display("FAIL rm_beats: got %0d expected 6", nbeats); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (beat_addr[i] !== exp[i]) begin errors++;
        $display("FAIL rm_addr[%0d]: got %h expected %h", i, beat_addr[i], exp[i]); end
      checks++; if (beat_last[i] !== (i == 5)) begin errors++;
        $display("FAIL rm_last[%0d]: got %b expected %b", i, beat_last[i], (i == 5)); end
    end
    checks++; if (done_at !== 1 || valid_at_done !== 1'b0) begin errors++;
      $display("FAIL rm_done: cycles_after_last=%0d valid=%b expected 1 and 0", done_at, valid_at_done); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rm_done_width: got %b expected 0", done); end
  endtask

  task automatic test_stall();
    logic [AW-1:0] exp [6];
    exp[0] = 12'h100; exp[1] = 12'h101; exp[2] = 12'h102;
    exp[3] = 12'h110; exp[4] = 12'h111; exp[5] = 12'h112;
    do_start(2, 3, 'h100, 'h10, 1'b0);
    collect(1'b1);
    checks++; if (nbeats !== 6) begin errors++; $display("FAIL st_beats: got %0d expected 6", nbeats); end
    checks++; if (stall_bad !== 0) begin errors++; $display("FAIL st_hold: %0d unstable stall cycles, expected 0", stall_bad); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (beat_addr[i] !== exp[i]) begin errors++;
        $display("FAIL st_addr[%0d]: got %h expected %h", i, beat_addr[i], exp[i]); end
    end
    checks++; if (beat_last[5] !== 1'b1) begin errors++; $display("FAIL st_last: got %b expected 1", beat_last[5]); end
    checks++; if (done_at !== 1) begin errors++; $display("FAIL st_done: got %0d expected 1", done_at); end
  endtask

  task automatic test_zero_tile();
    int dn = 0, vn = 0, bn = 0;
    do_start(0, 5, 'h040, 'h10, 1'b0);
    for (int c = 0; c < 5; c++) begin
      if (done) dn++;
      if (addr_valid) vn++;
      if (busy) bn++;
      @(negedge clk);
    end
    checks++; if (dn !== 1) begin errors++; $display("FAIL zero_done: pulses=%0d expected 1", dn); end
    checks++; if (vn !== 0) begin errors++; $display("FAIL zero_valid: cycles=%0d expected 0", vn); end
    checks++; if (bn !== 0) begin errors++; $display("FAIL zero_busy: cycles=%0d expected 0", bn); end
  endtask

  task automatic test_addr_wrap();
    logic [AW-1:0] exp [4];
    exp[0] = 12'hFFE; exp[1] = 12'hFFF; exp[2] = 12'h000; exp[3] = 12'h001;
    do_start(1, 4, 'hFFE, 'h001, 1'b0);
    collect(1'b0);
    checks++; if (nbeats !== 4) begin errors++; $display("FAIL wrap_beats: got %0d expected 4", nbeats); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (beat_addr[i] !== exp[i]) begin errors++;
        $display("FAIL wrap_addr[%0d]: got %h expected %h", i, beat_addr[i], exp[i]); end
    end
    checks++; if (beat_last[3] !== 1'b1) begin errors++; $display("FAIL wrap_last: got %b expected 1", beat_last[3]); end
  endtask

  task automatic test_clear();
    logic [AW-1:0] got [3];
    logic [AW-1:0] e;
    int dn = 0;
    do_start(4, 4, 'h200, 'h20, 1'b0);
    addr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      got[i] = addr;
      @(negedge clk);
    end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    checks++; if (addr_valid !== 1'b0 || busy !== 1'b0) begin errors++;
      $display("FAIL clr_drop: valid=%b busy=%b expected 0 0", addr_valid, busy); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (got[i] !== AW'('h200 + i)) begin errors++;
        $display("FAIL clr_pre[%0d]: got %h expected %h", i, got[i], AW'('h200 + i)); end
    end
    for (int c = 0; c < 5; c++) begin
      if (done) dn++;
      @(negedge clk);
    end
    checks++; if (dn !== 0) begin errors++; $display("FAIL clr_no_done: pulses=%0d expected 0", dn); end
    do_start(4, 4, 'h200, 'h20, 1'b0);
    collect(1'b0);
    checks++; if (nbeats !== 16) begin errors++; $display("FAIL clr_rerun_beats: got %0d expected 16", nbeats); end
    for (int i = 0; i < 16 && i < nbeats; i++) begin
      e = AW'('h200 + (i / 4) * 'h20 + (i % 4));
      checks++; if (beat_addr[i] !== e) begin errors++;
        $display("FAIL clr_rerun_addr[%0d]: got %h expected %h", i, beat_addr[i], e); end
    end
  endtask

  task automatic test_async_reset();
    int dn = 0;
    do_start(4, 4, 'h000, 'h10, 1'b0);
    addr_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++; if (addr_valid !== 1'b0 || busy !== 1'b0 || addr !== '0) begin errors++;
      $display("FAIL arst_now: valid=%b busy=%b addr=%h expected 0 0 000", addr_valid, busy, addr); end
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (done) dn++;
      @(negedge clk);
    end
    checks++; if (dn !== 0) begin errors++; $display("FAIL arst_no_done: pulses=%0d expected 0", dn); end
  endtask

`ifdef GCN_ADDR_SEQ_TRANSPOSE_EN
  task automatic test_transpose();
    logic [AW-1:0] exp [4];
    exp[0] = 12'h000; exp[1] = 12'h008; exp[2] = 12'h001; exp[3] = 12'h009;
    do_start(2, 2, 'h000, 'h008, 1'b1);
    collect(1'b0);
    checks++; if (nbeats !== 4) begin errors++; $display("FAIL tr_beats: got %0d expected 4", nbeats); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (beat_addr[i] !== exp[i]) begin errors++;
        $display("FAIL tr_addr[%0d]: got %h expected %h", i, beat_addr[i], exp[i]); end
      checks++; if (beat_last[i] !== (i == 3)) begin errors++;
        $display("FAIL tr_last[%0d]: got %b expected %b", i, beat_last[i], (i == 3)); end
    end
    cfg_col_major = 1'b0;
  endtask
`endif

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    test_row_major();
    test_stall();
    test_zero_tile();
    test_addr_wrap();
    test_clear();
    test_async_reset();
`ifdef GCN_ADDR_SEQ_TRANSPOSE_EN
    test_transpose();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
